// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter's start/data_in handshake, paced on busy.
// Optional UART_TXF_LEVEL_EN adds the registered fill level and almost_full outputs.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [7:0]   wr_data,
  output logic         full,
  output logic         empty,
  output logic         overflow,
  output logic         uart_start,
  output logic [7:0]   uart_data,
  input  logic         uart_busy
`ifdef UART_TXF_LEVEL_EN
  ,
  output logic [AW:0]  level,
  output logic         almost_full
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] COUNT_AF   = (AW+1)'(DEPTH - 2);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic          full_reg, empty_reg, overflow_reg;
  logic          uart_start_reg, start_next;
  logic [7:0]    uart_data_reg;
  state_t        state_reg, state_next;
  logic          push, pop;

  // Pushes are judged against the registered full flag, so a same-cycle pop never rescues them.
  assign push = wr_en && !full_reg;

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty_reg && !uart_busy) begin
          pop        = 1'b1;
          state_next = LAUNCH;
        end
      end
      LAUNCH: begin
        if (uart_busy) state_next = DRAIN;
      end
      DRAIN: begin
        if (!uart_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    start_next = (state_next == LAUNCH);
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + 1'b1;
    else if (!push && pop)
      count_next = count_reg - 1'b1;
  end

  // Storage array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= IDLE;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      full_reg       <= 1'b0;
      empty_reg      <= 1'b1;
      overflow_reg   <= 1'b0;
      uart_start_reg <= 1'b0;
      uart_data_reg  <= 8'h00;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      full_reg       <= (count_next == COUNT_FULL);
      empty_reg      <= (count_next == '0);
      overflow_reg   <= wr_en && full_reg;
      uart_start_reg <= start_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop) begin
        rd_ptr_reg    <= rd_ptr_reg + 1'b1;
        uart_data_reg <= mem[rd_ptr_reg];
      end
    end
  end

  assign full       = full_reg;
  assign empty      = empty_reg;
  assign overflow   = overflow_reg;
  assign uart_start = uart_start_reg;
  assign uart_data  = uart_data_reg;

`ifdef UART_TXF_LEVEL_EN
  logic almost_full_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) almost_full_reg <= 1'b0;
    else      almost_full_reg <= (count_next >= COUNT_AF);
  end

  assign level       = count_reg;
  assign almost_full = almost_full_reg;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: byte-queue reference model plus a behavioural transmitter.
// Define UART_TXF_LEVEL_EN to also check level/almost_full.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       uart_busy = 1'b0;
  logic       full, empty, overflow, uart_start;
  logic [7:0] uart_data;
`ifdef UART_TXF_LEVEL_EN
  logic [AW:0] level;
  logic        almost_full;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .overflow(overflow),
    .uart_start(uart_start), .uart_data(uart_data), .uart_busy(uart_busy)
`ifdef UART_TXF_LEVEL_EN
    , .level(level), .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: accepted bytes in write order, and how many are held.
  logic [7:0] q[$];
  int mcount = 0;
  bit prev_start = 1'b0;
  int launches = 0;

  // Behavioural transmitter: 0 idle, 1 start seen (waiting to go busy), 2 busy.
  int tx_phase = 0;
  int tx_cnt = 0;
  int tx_delay = 2;
  int tx_hold = 20;
  bit rnd_tx = 1'b0;
  bit tx_busy = 1'b0;
  bit force_busy = 1'b0;
  logic [7:0] tx_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_busy();
    uart_busy = tx_busy | force_busy;
  endtask

  task automatic tick();
    bit pushed;
    bit drop;
    logic [7:0] pdata;
    logic [7:0] exp_byte;
    @(posedge clk);
    pushed = wr_en;
    pdata  = wr_data;
    #1;
    drop = 1'b0;
    if (pushed) begin
      if (mcount == DEPTH) drop = 1'b1;
      else begin
        q.push_back(pdata);
        mcount++;
      end
    end
    check("overflow", overflow, drop);
    if (uart_start && !prev_start) begin
      if (q.size() == 0) check("spurious_launch", uart_start, 0);
      else begin
        exp_byte = q.pop_front();
        check("launch_data", uart_data, exp_byte);
        $display("launch %0d data=%02h", launches, uart_data);
        mcount--;
        launches++;
      end
    end
    if (tx_phase == 0) begin
      if (uart_start) begin
        tx_byte  = uart_data;
        tx_phase = 1;
        tx_cnt   = rnd_tx ? int'($urandom_range(1, 3)) : tx_delay;
      end
    end else if (tx_phase == 1) begin
      check("start_held", uart_start, 1);
      check("data_stable", uart_data, tx_byte);
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_busy  = 1'b1;
        tx_phase = 2;
        tx_cnt   = rnd_tx ? int'($urandom_range(1, 4)) : tx_hold;
      end
    end else begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_busy  = 1'b0;
        tx_phase = 0;
      end
    end
    prev_start = uart_start;
    check("empty", empty, mcount == 0);
    check("full", full, mcount == DEPTH);
`ifdef UART_TXF_LEVEL_EN
    check("level", level, mcount);
    check("almost_full", almost_full, mcount >= DEPTH - 2);
`endif
    drive_busy();
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || tx_phase != 0) && n < 3000) begin
      tick();
      n++;
    end
    check("drain_timeout", n < 3000, 1);
    repeat (4) tick();
  endtask

  initial begin
    int base;
    int sent;
    int guard;
    int n;

    // Reset with a push request held active.
    #3 rst = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'h55;
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_start", uart_start, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_empty", empty, 1);
    check("rst_hold_start", uart_start, 0);
    check("rst_hold_data", uart_data, 8'h00);
    check("rst_hold_ovf", overflow, 0);
    @(negedge clk);
    wr_en = 1'b0;
    rst   = 1'b1;
    repeat (2) tick();

    // Single byte: start one cycle after the push edge, busy arrives 5 clks later.
    tx_delay = 5;
    tx_hold  = 3;
    push(8'hA5);
    check("lat_empty", empty, 0);
    check("lat_no_start_yet", uart_start, 0);
    tick();
    check("lat_start", uart_start, 1);
    check("lat_data", uart_data, 8'hA5);
    drain();

    // Ordered burst against a slow transmitter.
    tx_delay = 2;
    tx_hold  = 20;
    base = launches;
    for (int i = 0; i < 16; i++) push(8'(i));
    drain();
    check("order_launches", launches - base, 16);

    // Overflow while the transmitter is held busy.
    force_busy = 1'b1;
    drive_busy();
    base = launches;
    for (int i = 0; i < 17; i++) begin
      push(8'(8'h10 + i));
      if (i == 15) check("full_at16", full, 1);
      if (i == 16) check("ovf_17th", overflow, 1);
    end
    tick();
    check("ovf_once", overflow, 0);
    check("no_pop_while_busy", launches - base, 0);
    force_busy = 1'b0;
    drive_busy();
    drain();
    check("ovf_launches", launches - base, 16);

    // Wrap: 40 bytes streamed with a randomly paced transmitter.
    rnd_tx = 1'b1;
    base = launches;
    sent = 0;
    guard = 0;
    while (sent < 40 && guard < 5000) begin
      if ($urandom_range(0, 2) != 0 && mcount < DEPTH) begin
        push(8'(8'h40 + sent));
        sent++;
      end else tick();
      guard++;
    end
    check("wrap_push_timeout", guard < 5000, 1);
    drain();
    check("wrap_launches", launches - base, 40);

    // Push while full in the same cycle as a pop: dropped.
    force_busy = 1'b1;
    drive_busy();
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    check("fill_full", full, 1);
    base = launches;
    force_busy = 1'b0;
    drive_busy();
    push(8'hEE);
    check("ovf_with_pop", overflow, 1);
    check("pop_same_cycle", uart_start, 1);
    drain();
    check("pop_cycle_launches", launches - base, 16);

    // Reset while a launch is pending acceptance, with 3 bytes still queued.
    rnd_tx = 1'b0;
    tx_delay = 10;
    tx_hold = 5;
    for (int i = 0; i < 4; i++) push(8'(8'hC0 + i));
    n = 0;
    while (!uart_start && n < 20) begin
      tick();
      n++;
    end
    check("launch_seen", uart_start, 1);
    check("queued_not_empty", empty, 0);
    base = launches;
    #2 rst = 1'b0;
    #1;
    check("midrst_start", uart_start, 0);
    check("midrst_empty", empty, 1);
    check("midrst_full", full, 0);
    check("midrst_data", uart_data, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    mcount = 0;
    prev_start = 1'b0;
    if (tx_phase == 1) begin
      tx_phase = 2;
      tx_busy  = 1'b1;
      tx_cnt   = tx_hold;
    end
    drive_busy();
    repeat (40) tick();
    check("midrst_no_launch", launches - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
